permutation_iter: RTL

PERMUTATION_ITER -- requirements
Module: permutation_iter

---
 rtl/ascon_pack.sv | 35 +++
 rtl/ascon_round.sv | 72 +++++++
 rtl/permutation_iter.sv | 84 ++++++++
 3 files changed

// File: rtl/ascon_pack.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_pack
//  Description : Shared types and constants for the iterative Ascon
//                permutation: 320-bit state type, controller state enum,
//                round-start constants and small round helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package ascon_pack;

  // Word i of the state holds Ascon lane x_i.
  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } type_fsm;

  localparam logic [3:0] C_ROUND_P12  = 4'd0;
  localparam logic [3:0] C_ROUND_P6   = 4'd6;
  localparam logic [3:0] C_ROUND_LAST = 4'd11;

  // Round constant byte: high nibble counts down from 0xF, low nibble is r.
  function automatic logic [7:0] round_const(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction

  // Rotate a 64-bit lane right by n positions (n in 1..63).
  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (32'd64 - n));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_round.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_round
//  Description : One combinational Ascon round: constant addition on lane 2,
//                bitsliced 5-bit S-box layer, then per-lane linear diffusion.
//  Revision    : 1.0 - initial release
// ============================================================================
module ascon_round
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  type_state   w_ca;
  type_state   w_sub;
  logic [63:0] w_s0, w_s1, w_s2, w_s3, w_s4;
  logic [63:0] w_t0, w_t1, w_t2, w_t3, w_t4;
  logic [63:0] w_u0, w_u1, w_u2, w_u3, w_u4;

  // Constant addition: only the low byte of lane 2 is touched.
  always_comb begin
    w_ca          = state_i;
    w_ca[2][7:0]  = state_i[2][7:0] ^ round_const(round_i);
  end

  // S-box input mixing.
  always_comb begin
    w_s0 = w_ca[0] ^ w_ca[4];
    w_s1 = w_ca[1];
    w_s2 = w_ca[2] ^ w_ca[1];
    w_s3 = w_ca[3];
    w_s4 = w_ca[4] ^ w_ca[3];
  end

  // Chi-like nonlinear core of the S-box.
  always_comb begin
    w_t0 = ~w_s0 & w_s1;
    w_t1 = ~w_s1 & w_s2;
    w_t2 = ~w_s2 & w_s3;
    w_t3 = ~w_s3 & w_s4;
    w_t4 = ~w_s4 & w_s0;
    w_u0 = w_s0 ^ w_t1;
    w_u1 = w_s1 ^ w_t2;
    w_u2 = w_s2 ^ w_t3;
    w_u3 = w_s3 ^ w_t4;
    w_u4 = w_s4 ^ w_t0;
  end

  // S-box output mixing.
  always_comb begin
    w_sub    = '0;
    w_sub[0] = w_u0 ^ w_u4;
    w_sub[1] = w_u1 ^ w_u0;
    w_sub[2] = ~w_u2;
    w_sub[3] = w_u3 ^ w_u2;
    w_sub[4] = w_u4;
  end

  // Linear diffusion: each lane XORed with two rotations of itself.
  always_comb begin
    state_o    = '0;
    state_o[0] = w_sub[0] ^ ror64(w_sub[0], 19) ^ ror64(w_sub[0], 28);
    state_o[1] = w_sub[1] ^ ror64(w_sub[1], 61) ^ ror64(w_sub[1], 39);
    state_o[2] = w_sub[2] ^ ror64(w_sub[2],  1) ^ ror64(w_sub[2],  6);
    state_o[3] = w_sub[3] ^ ror64(w_sub[3], 10) ^ ror64(w_sub[3], 17);
    state_o[4] = w_sub[4] ^ ror64(w_sub[4],  7) ^ ror64(w_sub[4], 41);
  end

endmodule
`default_nettype wire

// File: rtl/permutation_iter.sv
`default_nettype none
// ============================================================================
//  Module      : permutation_iter
//  Description : Iterative Ascon permutation, one round per clock. Supports
//                p12 (rounds 0..11) and p6 (rounds 6..11). Holds the result
//                from the DONE pulse until the next accepted start.
//  Revision    : 1.0 - initial release
// ============================================================================
module permutation_iter
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] round_o
);

  type_fsm    r_fsm;
  type_state  r_state;
  logic [3:0] r_round;
  logic       r_busy;
  logic       r_done;
  type_state  w_round_out;

  ascon_round u_round (
    .state_i (r_state),
    .round_i (r_round),
    .state_o (w_round_out)
  );

  // Controller, round counter and state register; outputs are registered.
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      r_fsm   <= ST_IDLE;
      r_state <= '0;
      r_round <= C_ROUND_P12;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (start_i) begin
            r_state <= state_i;
            r_round <= mode_i ? C_ROUND_P6 : C_ROUND_P12;
            r_busy  <= 1'b1;
            r_fsm   <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_state <= w_round_out;
          // The counter parks on the last round instead of wrapping.
          if (r_round == C_ROUND_LAST) begin
            r_done <= 1'b1;
            r_fsm  <= ST_DONE;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        ST_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          r_fsm  <= ST_IDLE;
        end
        default: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          r_fsm  <= ST_IDLE;
        end
      endcase
    end
  end

  assign state_o = r_state;
  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign round_o = r_round;

endmodule
`default_nettype wire
